// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot-load sequencer: FSM state encoding,
// the boot magic value and the header field layout.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CHK  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } boot_state_t;

  localparam logic [15:0] BOOT_MAGIC = 16'hB007;

  localparam int HDR_MAGIC_MSB = 31;
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_COUNT_MSB = 15;
  localparam int HDR_COUNT_LSB = 0;

  function automatic logic [15:0] hdrMagic(input logic [31:0] hdrWord);
    return hdrWord[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
  endfunction

  function automatic logic [15:0] hdrCount(input logic [31:0] hdrWord);
    return hdrWord[HDR_COUNT_MSB:HDR_COUNT_LSB];
  endfunction

endpackage

// File: rtl/boot_csum.sv
// Running 32-bit payload checksum: cleared by the header, accumulates each
// written payload word, and compares against the trailing checksum word.
// Only instantiated when BOOT_CHECKSUM_EN is defined.
module boot_csum (
  input  logic        clk_capture,
  input  logic        rst_p,
  input  logic        i_clear,
  input  logic        i_acc,
  input  logic [31:0] i_data,
  input  logic [31:0] i_cmp_data,
  output logic        o_match
);

  logic [31:0] r_sum;

  // Sum register: clear has priority so a new header always starts from zero
  always_ff @(posedge clk_capture or posedge rst_p) begin
    if (rst_p) begin
      r_sum <= 32'd0;
    end else if (i_clear) begin
      r_sum <= 32'd0;
    end else if (i_acc) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_match = (r_sum == i_cmp_data);

endmodule

// File: rtl/uart_boot_ctrl.sv
// Boot-load sequencer: parses a header word from the UART word receiver,
// writes the payload to consecutive instruction-memory words starting at
// address 0, and holds the CPU in reset until the load finishes.
// Optional feature macro: BOOT_CHECKSUM_EN adds a trailing checksum word
// that must equal the 32-bit sum of the payload.
module uart_boot_ctrl #(
  parameter int          ADDR_W     = 16,
  parameter int          MAX_WORDS  = 4096,
  parameter logic [15:0] BOOT_MAGIC = boot_pkg::BOOT_MAGIC
) (
  input  logic              clk_capture,
  input  logic              rst_p,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  import boot_pkg::*;

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t POST_LOAD_STATE = ST_CHK;
`else
  localparam boot_state_t POST_LOAD_STATE = ST_DONE;
`endif

  boot_state_t       r_state;
  boot_state_t       w_next_state;
  logic              w_write;
  logic              w_latch_count;
  logic [15:0]       w_hdr_magic;
  logic [15:0]       w_hdr_count;
  logic [15:0]       r_remaining;
  logic [ADDR_W-1:0] r_wptr;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_cpu_hold;
  logic              r_load_done;
  logic              r_load_err;
  logic [15:0]       r_words_loaded;

  assign w_hdr_magic = hdrMagic(word_data);
  assign w_hdr_count = hdrCount(word_data);

`ifdef BOOT_CHECKSUM_EN
  logic w_csum_clear;
  logic w_csum_acc;
  logic w_csum_match;

  boot_csum u_csum (
    .clk_capture (clk_capture),
    .rst_p       (rst_p),
    .i_clear     (w_csum_clear),
    .i_acc       (w_csum_acc),
    .i_data      (word_data),
    .i_cmp_data  (word_data),
    .o_match     (w_csum_match)
  );
`endif

  // State register
  always_ff @(posedge clk_capture or posedge rst_p) begin
    if (rst_p) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: header parsing, payload counting and checksum verdict
  always_comb begin
    w_next_state  = r_state;
    w_write       = 1'b0;
    w_latch_count = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    w_csum_clear  = 1'b0;
    w_csum_acc    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (word_valid) begin
`ifdef BOOT_CHECKSUM_EN
          w_csum_clear = 1'b1;
`endif
          if (w_hdr_magic != BOOT_MAGIC) begin
            w_next_state = ST_ERR;
          end else if (int'(w_hdr_count) > MAX_WORDS) begin
            w_next_state = ST_ERR;
          end else if (w_hdr_count == 16'd0) begin
            w_next_state = POST_LOAD_STATE;
          end else begin
            w_next_state  = ST_LOAD;
            w_latch_count = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (word_valid) begin
          w_write = 1'b1;
`ifdef BOOT_CHECKSUM_EN
          w_csum_acc = 1'b1;
`endif
          if (r_remaining == 16'd1) begin
            w_next_state = POST_LOAD_STATE;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHK: begin
        if (word_valid) begin
          w_next_state = w_csum_match ? ST_DONE : ST_ERR;
        end
      end
`endif
      ST_DONE: w_next_state = ST_DONE;
      ST_ERR:  w_next_state = ST_ERR;
      default: w_next_state = ST_ERR;
    endcase
  end

  // Write port, counters and status flags, all registered off the decode
  always_ff @(posedge clk_capture or posedge rst_p) begin
    if (rst_p) begin
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= 32'd0;
      r_wptr         <= '0;
      r_remaining    <= 16'd0;
      r_words_loaded <= 16'd0;
      r_cpu_hold     <= 1'b1;
      r_load_done    <= 1'b0;
      r_load_err     <= 1'b0;
    end else begin
      r_imem_we   <= w_write;
      r_cpu_hold  <= (w_next_state != ST_DONE);
      r_load_done <= (w_next_state == ST_DONE);
      r_load_err  <= (w_next_state == ST_ERR);
      if (w_latch_count) begin
        r_remaining <= w_hdr_count;
      end
      if (w_write) begin
        r_imem_addr    <= r_wptr;
        r_imem_wdata   <= word_data;
        r_wptr         <= r_wptr + ADDR_W'(4);
        r_remaining    <= r_remaining - 16'd1;
        r_words_loaded <= r_words_loaded + 16'd1;
      end
    end
  end

  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign cpu_hold     = r_cpu_hold;
  assign load_done    = r_load_done;
  assign load_err     = r_load_err;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Directed testbench for uart_boot_ctrl. Expected values are hand-computed;
// checksum-specific steps are selected with BOOT_CHECKSUM_EN.
module tb_uart_boot_ctrl;

  logic        clk_capture = 1'b0;
  logic        rst_p       = 1'b1;
  logic        word_valid  = 1'b0;
  logic [31:0] word_data   = 32'd0;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  int checks  = 0;
  int errors  = 0;
  int weCount = 0;
  int weBase  = 0;

  uart_boot_ctrl dut (
    .clk_capture  (clk_capture),
    .rst_p        (rst_p),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk_capture = ~clk_capture;

  // Counts strobes seen on each rising edge (lags the strobe by half a cycle)
  always @(posedge clk_capture) begin
    if (imem_we) weCount <= weCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one word for a single cycle; returns on the negedge where the
  // registered response to that word is visible.
  task automatic applyStimulus(input logic [31:0] data);
    @(negedge clk_capture);
    word_valid = 1'b1;
    word_data  = data;
    @(negedge clk_capture);
    word_valid = 1'b0;
  endtask

  task automatic resetDut();
    @(negedge clk_capture);
    rst_p = 1'b1;
    @(negedge clk_capture);
    @(negedge clk_capture);
    rst_p = 1'b0;
  endtask

  initial begin
    // Reset values
    resetDut();
    checkOutput("rst_we",    32'(imem_we),      32'd0);
    checkOutput("rst_addr",  32'(imem_addr),    32'd0);
    checkOutput("rst_wdata", imem_wdata,        32'd0);
    checkOutput("rst_hold",  32'(cpu_hold),     32'd1);
    checkOutput("rst_done",  32'(load_done),    32'd0);
    checkOutput("rst_err",   32'(load_err),     32'd0);
    checkOutput("rst_words", 32'(words_loaded), 32'd0);

    // Normal three-word load
    applyStimulus(32'hB007_0003);
    checkOutput("hdr_no_we", 32'(imem_we),  32'd0);
    checkOutput("hdr_hold",  32'(cpu_hold), 32'd1);
    applyStimulus(32'd11);
    checkOutput("w0_we",    32'(imem_we),   32'd1);
    checkOutput("w0_addr",  32'(imem_addr), 32'h0);
    checkOutput("w0_data",  imem_wdata,     32'd11);
    checkOutput("w0_done",  32'(load_done), 32'd0);
    applyStimulus(32'd22);
    checkOutput("w1_addr",  32'(imem_addr), 32'h4);
    checkOutput("w1_data",  imem_wdata,     32'd22);
    applyStimulus(32'd33);
    checkOutput("w2_we",    32'(imem_we),      32'd1);
    checkOutput("w2_addr",  32'(imem_addr),    32'h8);
    checkOutput("w2_data",  imem_wdata,        32'd33);
    checkOutput("w2_words", 32'(words_loaded), 32'd3);
`ifdef BOOT_CHECKSUM_EN
    checkOutput("w2_done_pending", 32'(load_done), 32'd0);
    checkOutput("w2_hold_pending", 32'(cpu_hold),  32'd1);
    applyStimulus(32'd66);
    checkOutput("csum_we",   32'(imem_we),   32'd0);
`endif
    checkOutput("load_done", 32'(load_done), 32'd1);
    checkOutput("load_hold", 32'(cpu_hold),  32'd0);
    checkOutput("load_err",  32'(load_err),  32'd0);
    applyStimulus(32'h1234_5678);
    checkOutput("trail_we",    32'(imem_we),      32'd0);
    checkOutput("trail_done",  32'(load_done),    32'd1);
    checkOutput("trail_words", 32'(words_loaded), 32'd3);

    // Bad magic
    resetDut();
    weBase = weCount;
    applyStimulus(32'hDEAD_0002);
    checkOutput("magic_err",  32'(load_err),  32'd1);
    checkOutput("magic_hold", 32'(cpu_hold),  32'd1);
    checkOutput("magic_done", 32'(load_done), 32'd0);
    applyStimulus(32'd5);
    applyStimulus(32'd6);
    @(negedge clk_capture);
    @(negedge clk_capture);
    checkOutput("magic_no_writes", 32'(weCount - weBase), 32'd0);
    checkOutput("magic_err_sticky", 32'(load_err), 32'd1);

    // Length just above and exactly at the limit
    resetDut();
    applyStimulus(32'hB007_1001);
    checkOutput("len_over_err", 32'(load_err), 32'd1);
    resetDut();
    applyStimulus(32'hB007_1000);
    checkOutput("len_max_err",  32'(load_err), 32'd0);
    checkOutput("len_max_hold", 32'(cpu_hold), 32'd1);

    // Empty program
    resetDut();
    applyStimulus(32'hB007_0000);
`ifdef BOOT_CHECKSUM_EN
    checkOutput("zero_done_pending", 32'(load_done), 32'd0);
    applyStimulus(32'd0);
`endif
    checkOutput("zero_done", 32'(load_done), 32'd1);
    checkOutput("zero_hold", 32'(cpu_hold),  32'd0);

`ifdef BOOT_CHECKSUM_EN
    // Checksum good and bad
    resetDut();
    applyStimulus(32'hB007_0003);
    applyStimulus(32'd1);
    applyStimulus(32'd2);
    applyStimulus(32'd3);
    applyStimulus(32'd6);
    checkOutput("csum_ok_done", 32'(load_done), 32'd1);
    resetDut();
    weBase = weCount;
    applyStimulus(32'hB007_0003);
    applyStimulus(32'd1);
    applyStimulus(32'd2);
    applyStimulus(32'd3);
    applyStimulus(32'd7);
    checkOutput("csum_bad_err",  32'(load_err),  32'd1);
    checkOutput("csum_bad_hold", 32'(cpu_hold),  32'd1);
    @(negedge clk_capture);
    @(negedge clk_capture);
    checkOutput("csum_bad_writes", 32'(weCount - weBase), 32'd3);
`endif

    // Reset in the middle of a load
    resetDut();
    applyStimulus(32'hB007_0004);
    applyStimulus(32'hAAAA_0001);
    applyStimulus(32'hAAAA_0002);
    checkOutput("mid_words_before", 32'(words_loaded), 32'd2);
    @(negedge clk_capture);
    rst_p = 1'b1;
    #1;
    checkOutput("mid_rst_words", 32'(words_loaded), 32'd0);
    checkOutput("mid_rst_addr",  32'(imem_addr),    32'd0);
    @(negedge clk_capture);
    rst_p = 1'b0;
    applyStimulus(32'hB007_0001);
    applyStimulus(32'd55);
    checkOutput("mid_we",    32'(imem_we),      32'd1);
    checkOutput("mid_addr",  32'(imem_addr),    32'h0);
    checkOutput("mid_data",  imem_wdata,        32'd55);
    checkOutput("mid_words", 32'(words_loaded), 32'd1);
`ifdef BOOT_CHECKSUM_EN
    applyStimulus(32'd55);
`endif
    checkOutput("mid_done", 32'(load_done), 32'd1);

    // Header and payload on consecutive cycles
    resetDut();
    weBase = weCount;
    @(negedge clk_capture);
    word_valid = 1'b1;
    word_data  = 32'hB007_0004;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_capture);
      if (i == 0) begin
        checkOutput("b2b_hdr_we", 32'(imem_we), 32'd0);
      end else begin
        checkOutput("b2b_we",   32'(imem_we),   32'd1);
        checkOutput("b2b_addr", 32'(imem_addr), 32'(4 * (i - 1)));
        checkOutput("b2b_data", imem_wdata,     32'hA000_0000 + 32'(i - 1));
      end
      word_data = 32'hA000_0000 + 32'(i);
    end
    @(negedge clk_capture);
    word_valid = 1'b0;
    checkOutput("b2b_last_we",   32'(imem_we),      32'd1);
    checkOutput("b2b_last_addr", 32'(imem_addr),    32'hC);
    checkOutput("b2b_last_data", imem_wdata,        32'hA000_0003);
    checkOutput("b2b_words",     32'(words_loaded), 32'd4);
`ifdef BOOT_CHECKSUM_EN
    checkOutput("b2b_done_pending", 32'(load_done), 32'd0);
`else
    checkOutput("b2b_done", 32'(load_done), 32'd1);
`endif
    @(negedge clk_capture);
    checkOutput("b2b_we_off", 32'(imem_we), 32'd0);
    @(negedge clk_capture);
    checkOutput("b2b_write_count", 32'(weCount - weBase), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
